// File: rtl/alu4bit_issue.sv
// rtl/alu4bit_issue.sv - command FIFO and issue/capture FSM around the 4-bit ALU
module alu4bit_issue #(
  parameter int OPQ_DEPTH = 4,
  parameter int ALU_LAT   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [3:0]                   cmd_a,
  input  logic [3:0]                   cmd_b,
  input  logic [1:0]                   cmd_oc,
  output logic [3:0]                   alu_a,
  output logic [3:0]                   alu_b,
  output logic [1:0]                   alu_oc,
  input  logic [3:0]                   alu_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [3:0]                   res_data,
  output logic [1:0]                   res_oc,
  output logic                         busy,
  output logic [$clog2(OPQ_DEPTH):0]   cmd_count
);

  localparam int AW = (OPQ_DEPTH > 1) ? $clog2(OPQ_DEPTH) : 1;
  localparam int CW = $clog2(OPQ_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(OPQ_DEPTH);
  localparam logic [1:0]    WLOAD   = 2'(ALU_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t          state, state_nxt;
  logic [9:0]      mem [OPQ_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [1:0]      wcnt;
  logic [1:0]      shadow_oc;
  logic            push, pop, capture, empty;
  logic [9:0]      head;

  // Ready depends only on the registered count, so a pop never enables a push into a full FIFO.
  assign cmd_ready = (cmd_count < DEPTH_C);
  assign push      = cmd_valid && cmd_ready;
  assign empty     = (cmd_count == '0);
  assign head      = mem[rd_ptr];
  assign busy      = (state != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_a, cmd_b, cmd_oc};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cmd_count <= cmd_count + 1'b1;
        2'b01:   cmd_count <= cmd_count - 1'b1;
        default: cmd_count <= cmd_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt == 2'd0) begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operands stay put between pops so the ALU output remains stable through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_oc    <= '0;
      shadow_oc <= '0;
      wcnt      <= '0;
      res_data  <= '0;
      res_oc    <= '0;
      res_valid <= 1'b0;
    end else begin
      if (pop) begin
        alu_a     <= head[9:6];
        alu_b     <= head[5:2];
        alu_oc    <= head[1:0];
        shadow_oc <= head[1:0];
        wcnt      <= WLOAD;
      end else if (state == S_WAIT && wcnt != 2'd0) begin
        wcnt <= wcnt - 2'd1;
      end
      if (capture) begin
        res_data <= alu_out;
        res_oc   <= shadow_oc;
      end
      res_valid <= (state_nxt == S_HOLD);
    end
  end

endmodule

// File: tb/tb_alu4bit_issue.sv
// tb/tb_alu4bit_issue.sv - scoreboard bench for alu4bit_issue at ALU_LAT 1 and 3
module tb_alu4bit_issue;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_valid1 = 0, cmd_ready1, res_valid1, res_ready1 = 0, busy1;
  logic [3:0] cmd_a1 = 0, cmd_b1 = 0, alu_a1, alu_b1, alu_out1, res_data1;
  logic [1:0] cmd_oc1 = 0, alu_oc1, res_oc1;
  logic [2:0] cmd_count1;

  logic       cmd_valid3 = 0, cmd_ready3, res_valid3, res_ready3 = 0, busy3;
  logic [3:0] cmd_a3 = 0, cmd_b3 = 0, alu_a3, alu_b3, alu3_val = 0, res_data3;
  logic [1:0] cmd_oc3 = 0, alu_oc3, res_oc3;
  logic [2:0] cmd_count3;

  logic xor_mode = 0;
  int   checks = 0, failures = 0, cyc = 0;
  logic [5:0] sb1[$], sb3[$];
  int   hs1_t[$];

  always_comb begin
    alu_out1 = 4'h0;
    if (xor_mode)                alu_out1 = alu_a1 ^ alu_b1;
    else if (alu_oc1 == 2'b00)   alu_out1 = alu_a1 + alu_b1;
    else                         alu_out1 = alu_a1 - alu_b1;
  end

  alu4bit_issue #(.OPQ_DEPTH(4), .ALU_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_a(cmd_a1), .cmd_b(cmd_b1), .cmd_oc(cmd_oc1), .alu_a(alu_a1), .alu_b(alu_b1),
    .alu_oc(alu_oc1), .alu_out(alu_out1), .res_valid(res_valid1), .res_ready(res_ready1),
    .res_data(res_data1), .res_oc(res_oc1), .busy(busy1), .cmd_count(cmd_count1));

  alu4bit_issue #(.OPQ_DEPTH(4), .ALU_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_oc(cmd_oc3), .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_oc(alu_oc3), .alu_out(alu3_val), .res_valid(res_valid3), .res_ready(res_ready3),
    .res_data(res_data3), .res_oc(res_oc3), .busy(busy3), .cmd_count(cmd_count3));

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitors sample just after the falling edge, once the bench has set res_ready.
  initial forever begin
    logic [5:0] e;
    @(negedge clk); #1;
    if (rst_n && res_valid1 && res_ready1) begin
      hs1_t.push_back(cyc);
      if (sb1.size() == 0) chk("res1_unexpected_valid", res_valid1, 0);
      else begin
        e = sb1.pop_front();
        chk("res1_data", res_data1, e[3:0]);
        chk("res1_oc", res_oc1, e[5:4]);
      end
    end
  end

  initial forever begin
    logic [5:0] e;
    @(negedge clk); #1;
    if (rst_n && res_valid3 && res_ready3) begin
      if (sb3.size() == 0) chk("res3_unexpected_valid", res_valid3, 0);
      else begin
        e = sb3.pop_front();
        chk("res3_data", res_data3, e[3:0]);
        chk("res3_oc", res_oc3, e[5:4]);
      end
    end
  end

  task automatic send1(input logic [3:0] a, input logic [3:0] b, input logic [1:0] oc,
                       input logic [5:0] expv);
    int n = 0;
    cmd_a1 = a; cmd_b1 = b; cmd_oc1 = oc; cmd_valid1 = 1'b1;
    while (!cmd_ready1 && n < 20) begin @(negedge clk); n++; end
    if (!cmd_ready1) chk("cmd1_accept_timeout", cmd_ready1, 1);
    sb1.push_back(expv);
    @(negedge clk);
    cmd_valid1 = 1'b0;
  endtask

  initial begin
    int n;
    // Reset with random inputs
    repeat (3) begin
      @(negedge clk);
      cmd_valid1 = 1'($urandom); cmd_a1 = 4'($urandom); cmd_b1 = 4'($urandom);
      cmd_oc1 = 2'($urandom); res_ready1 = 1'($urandom);
    end
    chk("rst_hold_res_valid", res_valid1, 0);
    chk("rst_hold_count", cmd_count1, 0);
    cmd_valid1 = 0; res_ready1 = 0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready1, 1);
    chk("rst_res_valid", res_valid1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_count", cmd_count1, 0);
    chk("rst_alu_abo", {alu_a1, alu_b1, alu_oc1}, 0);
    chk("rst_res_data_oc", {res_data1, res_oc1}, 0);
    chk("rst3_cmd_ready", cmd_ready3, 1);

    // Single command, ALU_LAT=1: 3+5 -> 8
    res_ready1 = 1;
    send1(4'd3, 4'd5, 2'b00, {2'b00, 4'h8});
    chk("single_count_after_push", cmd_count1, 1);
    chk("single_busy", busy1, 1);
    chk("single_no_bypass_alu_a", alu_a1, 0);
    @(negedge clk);
    chk("single_alu_a", alu_a1, 3);
    chk("single_alu_b", alu_b1, 5);
    chk("single_valid_early", res_valid1, 0);
    @(negedge clk);
    chk("single_valid", res_valid1, 1);
    chk("single_data", res_data1, 8);
    @(negedge clk);
    chk("single_valid_drop", res_valid1, 0);
    chk("single_busy_idle", busy1, 0);

    // Backpressure: fill FIFO behind a held result
    res_ready1 = 0; xor_mode = 1;
    for (int i = 1; i <= 5; i++) send1(4'(i), 4'hF, 2'b10, {2'b10, 4'(i) ^ 4'hF});
    chk("full_count", cmd_count1, 4);
    chk("full_cmd_ready", cmd_ready1, 0);
    chk("full_res_valid", res_valid1, 1);
    cmd_a1 = 4'd6; cmd_b1 = 4'hF; cmd_oc1 = 2'b10; cmd_valid1 = 1;
    repeat (3) @(negedge clk);
    chk("full_sixth_held_count", cmd_count1, 4);
    chk("full_sixth_held_ready", cmd_ready1, 0);
    chk("full_res_data_stable", res_data1, 4'hE);
    cmd_valid1 = 0;

    // Drain in order, one result every 2 cycles
    hs1_t.delete();
    res_ready1 = 1;
    n = 0;
    while (hs1_t.size() < 5 && n < 60) begin @(negedge clk); n++; end
    chk("drain_results", hs1_t.size(), 5);
    for (int k = 1; k < 5 && k < hs1_t.size(); k++)
      chk("drain_spacing", hs1_t[k] - hs1_t[k-1], 2);
    n = 0;
    while (busy1 && n < 20) begin @(negedge clk); n++; end
    chk("drain_busy", busy1, 0);
    chk("drain_count", cmd_count1, 0);
    chk("drain_sb_empty", sb1.size(), 0);
    xor_mode = 0;

    // ALU_LAT=3: 7-2 -> 5, alu_out disturbed mid-wait
    res_ready3 = 1;
    cmd_a3 = 4'd7; cmd_b3 = 4'd2; cmd_oc3 = 2'b01; cmd_valid3 = 1;
    sb3.push_back({2'b01, 4'h5});
    @(negedge clk);
    cmd_valid3 = 0;
    for (int k = 1; k <= 4; k++) begin
      chk("lat3_valid_low", res_valid3, 0);
      if (k == 2) alu3_val = 4'hA;
      if (k == 4) alu3_val = 4'h5;
      @(negedge clk);
    end
    chk("lat3_valid", res_valid3, 1);
    chk("lat3_data", res_data3, 5);
    chk("lat3_oc", res_oc3, 1);
    repeat (2) @(negedge clk);
    chk("lat3_sb_empty", sb3.size(), 0);

    // Asynchronous reset in the middle of WAIT drops everything
    res_ready3 = 0;
    for (int k = 0; k < 3; k++) begin
      cmd_a3 = 4'(k + 9); cmd_b3 = 4'd1; cmd_oc3 = 2'b00; cmd_valid3 = 1;
      @(negedge clk);
    end
    cmd_valid3 = 0;
    chk("midwait_count", cmd_count3, 2);
    chk("midwait_busy", busy3, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_count", cmd_count3, 0);
    chk("async_rst_valid", res_valid3, 0);
    chk("async_rst_busy", busy3, 0);
    chk("async_rst_alu_a", alu_a3, 0);
    @(negedge clk);
    rst_n = 1; res_ready3 = 1;
    sb1.delete(); sb3.delete();
    repeat (12) @(negedge clk);
    chk("post_rst_valid", res_valid3, 0);
    chk("post_rst_busy", busy3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/alu4bit_issue.md
Name: alu4bit_issue

Overview:
Command-issue and result-capture stage wrapped around the 4-bit ALU. It buffers incoming (a, b, oc) commands in a small FIFO and drives them onto the combinational ALU one at a time. After a programmable settle time it samples the ALU result and presents it downstream with a valid/ready handshake. It sits directly upstream of the ALU's operand and opcode inputs, and directly downstream of its output.

Parameters:
OPQ_DEPTH, 4, command FIFO depth in entries; power of two, 2..16.
ALU_LAT, 1, cycles from operands appearing on alu_* to alu_out being sampled; 1..3.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
cmd_valid  input  1  command present.
cmd_ready  output  1  FIFO can accept a command.
cmd_a  input  4  operand A.
cmd_b  input  4  operand B.
cmd_oc  input  2  ALU opcode.
alu_a  output  4  registered operand A to ALU.
alu_b  output  4  registered operand B to ALU.
alu_oc  output  2  registered opcode to ALU.
alu_out  input  4  ALU result (combinational from alu_*).
res_valid  output  1  result held for downstream.
res_ready  input  1  downstream accepts result.
res_data  output  4  captured ALU result.
res_oc  output  2  opcode that produced res_data.
busy  output  1  high whenever the FSM is not IDLE or the FIFO is non-empty.
cmd_count  output  clog2(OPQ_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; cmd_count=0.
  - FSM in IDLE.
  - alu_a, alu_b, alu_oc, res_data, res_oc = 0.
  - res_valid=0, busy=0.
  - cmd_ready=1 on the first cycle after release.
  - Reset mid-operation drops all queued and in-flight commands. No result is emitted for them.
- Push: a command is pushed on a rising edge when cmd_valid && cmd_ready.
  - cmd_ready = (cmd_count < OPQ_DEPTH). It is registered-count based, with no combinational dependence on pop.
  - When full, a simultaneous pop does not permit a push that cycle.
- Pop: pops are taken only by the FSM. Simultaneous push and pop with the FIFO non-full leaves cmd_count unchanged.
- FIFO: FIFO order is preserved end to end.
- FSM states:
  - IDLE:
    - FIFO non-empty: pop the head into alu_a/alu_b/alu_oc and a shadow opcode register, load wcnt=ALU_LAT-1, go to WAIT.
    - Otherwise stay in IDLE.
  - WAIT:
    - wcnt!=0: decrement wcnt.
    - wcnt==0: capture res_data<=alu_out and res_oc<=shadow opcode, set res_valid<=1, go to HOLD.
  - HOLD: res_valid=1; res_data and res_oc stable.
    - Stay in HOLD while res_ready=0.
    - On res_ready=1, if the FIFO is non-empty: pop the next command in the same edge, load wcnt, clear res_valid, go to WAIT.
    - On res_ready=1, if the FIFO is empty: clear res_valid, go to IDLE.
- alu_a, alu_b, alu_oc change only on a pop edge. They hold their last value otherwise.
- Latency:
  - Command pushed at edge E0 into an empty, idle block: operands on alu_* after E1, alu_out sampled at edge E1+ALU_LAT, res_valid high from that edge.
  - With ALU_LAT=1, res_valid rises 2 edges after the accept edge.
- Throughput with res_ready held high: one result every ALU_LAT+1 cycles.
- A command pushed into an empty FIFO while in IDLE cannot be popped on the same edge. There is no bypass.
- No arithmetic is done in this block. Widths pass through unchanged.

Test Plan:
- Reset: hold rst_n=0 with random inputs, release -> all outputs 0 except cmd_ready=1. Assert rst_n=0 asynchronously between clock edges -> outputs clear immediately.
- Single command (ALU_LAT=1; bench ALU model returns a+b mod 16 for oc=00): push a=3, b=5, oc=00 at E0 with res_ready=1 -> alu_a=3, alu_b=5 after E1; at E2 res_valid=1, res_data=4'h8, res_oc=00; res_valid drops at E3; busy returns to 0.
- Backpressure/full (OPQ_DEPTH=4): res_ready=0, push 6 commands back-to-back -> first is popped into WAIT/HOLD; next 4 fill the FIFO (cmd_count=4, cmd_ready=0); 6th is held off; with res_ready still 0, res_data does not change.
- Drain order: from the full state set res_ready=1 with the bench model returning a^b; commands a=1..5, b=F -> five results E,D,C,B,A in order, spaced 2 cycles apart; cmd_count reaches 0; FSM returns to IDLE.
- Latency parameter (ALU_LAT=3): single push a=7, b=2, oc=01 -> res_valid exactly 4 edges after accept. The bench changes alu_out mid-WAIT, and only the value present at the capture edge appears on res_data.
- Reset mid-WAIT: push 3 commands, assert rst_n=0 during WAIT -> cmd_count=0, res_valid=0 immediately; no stale result after release.
